// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       parity_in,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        ptype_q, ptype_d;
  logic              pbit_q, pbit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_tc;
  logic              stop_last;
`ifdef UART_TX_TWO_STOP_EN
  logic              stop_q, stop_d;
`endif

  // State and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptype_q <= '0;
      pbit_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptype_q <= ptype_d;
      pbit_q  <= pbit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_q  <= stop_d;
`endif
    end
  end

  // Next-state, baud timing and registered output decode
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptype_d = ptype_q;
    pbit_d  = pbit_q;
    done_d  = 1'b0;
    baud_tc = (baud_q == BAUD_LAST);
`ifdef UART_TX_TWO_STOP_EN
    stop_d    = stop_q;
    stop_last = stop_q;
`else
    stop_last = 1'b1;
`endif

    if (state_q != IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = data_in;
          ptype_d = parity_type;
          pbit_d  = parity_in;
`ifdef UART_TX_TWO_STOP_EN
          stop_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
      end
      DATA: begin
        if (baud_tc) begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = (|ptype_q) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (baud_tc) state_d = STOP;
      end
      STOP: begin
        if (baud_tc) begin
          if (stop_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef UART_TX_TWO_STOP_EN
            stop_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx_out stays registered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = pbit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: per-cycle scoreboard of {tx_out, busy, done}.
module tb_uart_tx_frame;
  localparam int unsigned CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_N = 2;
`else
  localparam int unsigned STOP_N = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       parity_in = 1'b0;
  logic       tx_out, busy, done;

  int errors = 0;
  int checks = 0;
  int busy_cyc = 0;
  logic [2:0] sb[$];

  uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .parity_type(parity_type), .parity_in(parity_in),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_bit(input logic b);
    repeat (CPB) sb.push_back({b, 2'b10});
  endtask

  task automatic push_idle(input int n);
    repeat (n) sb.push_back(3'b100);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
    if (pt != 2'b00) push_bit(pb);
    repeat (STOP_N) push_bit(1'b1);
    sb.push_back(3'b101);
  endtask

  // One cycle: sample at negedge and compare against the scoreboard head
  task automatic step(input string tag);
    logic [2:0] e;
    logic [2:0] obs;
    @(negedge clk);
    obs = {tx_out, busy, done};
    if (busy === 1'b1) busy_cyc++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed {tx,busy,done}=%b", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: {tx,busy,done} observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) step(tag);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb);
    data_in     = d;
    parity_type = pt;
    parity_in   = pb;
    tx_start    = 1'b1;
    push_frame(d, pt, pb);
    busy_cyc = 0;
  endtask

  task automatic check_len(input string tag, input logic [1:0] pt);
    int exp_len;
    exp_len = (10 + ((pt != 2'b00) ? 1 : 0) + STOP_N - 1) * CPB;
    checks++;
    assert (busy_cyc === exp_len) else begin
      errors++;
      $error("FAIL %s: busy cycles observed=%0d expected=%0d", tag, busy_cyc, exp_len);
    end
  endtask

  initial begin
    // 1: reset held, tx_start toggling
    push_idle(10);
    for (int i = 0; i < 10; i++) begin
      tx_start = i[0];
      step("reset_hold");
    end
    tx_start = 1'b0;
    rst = 1'b0;
    push_idle(2);
    drain("post_reset_idle");

    // 2: 0x55, no parity
    start_frame(8'h55, 2'b00, 1'b0);
    step("f55"); tx_start = 1'b0;
    drain("f55");
    check_len("f55_len", 2'b00);
    push_idle(2);
    drain("f55_idle");

    // 3: 0xA5 even parity; data_in changes mid-frame
    start_frame(8'hA5, 2'b10, 1'b0);
    step("fA5"); tx_start = 1'b0;
    repeat (12) step("fA5");
    data_in = 8'h3C; parity_in = 1'b1; parity_type = 2'b00;
    drain("fA5");
    check_len("fA5_len", 2'b10);
    push_idle(1);
    drain("fA5_idle");

    // 4: 0x01 odd; mid-frame tx_start ignored; back-to-back in done cycle
    start_frame(8'h01, 2'b01, 1'b0);
    step("f01"); tx_start = 1'b0;
    repeat (20) step("f01");
    tx_start = 1'b1; data_in = 8'hEE;
    step("f01_ignored");
    tx_start = 1'b0;
    drain("f01");
    check_len("f01_len", 2'b01);
    start_frame(8'hC3, 2'b11, 1'b1);
    step("fC3_b2b"); tx_start = 1'b0;
    drain("fC3");
    check_len("fC3_len", 2'b11);
    push_idle(2);
    drain("fC3_idle");

    // 5: reset during data bit 3 aborts with no done
    start_frame(8'h96, 2'b00, 1'b0);
    step("f96"); tx_start = 1'b0;
    repeat (16) step("f96");
    sb.delete();
    rst = 1'b1;
    push_idle(2);
    drain("abort_rst");
    rst = 1'b0;
    push_idle(CPB * 12);
    drain("abort_no_done");
    start_frame(8'h5A, 2'b10, 1'b1);
    step("f5A"); tx_start = 1'b0;
    drain("f5A");
    check_len("f5A_len", 2'b10);

`ifdef UART_TX_TWO_STOP_EN
    // 6: two stop bits
    start_frame(8'hFF, 2'b00, 1'b0);
    step("fFF"); tx_start = 1'b0;
    drain("fFF");
    check_len("fFF_len", 2'b00);
`endif
    push_idle(2);
    drain("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
